lsu_dm_master: RTL and testbench
================================

Name: lsu_dm_master

Overview:
Load/store initiator that drives the word-addressed data-memory port (DM_enable/DM_read/DM_write/DM_address/DM_in/DM_out) on behalf of the CPU core.
- Accepts byte-addressed load/store requests with RISC-V funct3 sizes.
- Sequences the memory's 1-cycle registered read.
- Extracts and extends bytes/halves on loads.
- Performs read-modify-write for sub-word stores, since the memory writes whole words only.

Parameters:
ADDR_W, 12, data-memory word-address width; byte address is ADDR_W+2 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (clears on rising clk edge while rst=0)
req_valid  in  1  core request present
req_ready  out  1  LSU can accept; =1 iff state IDLE
req_write  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load result; 0 for stores/errors
rsp_err  out  1  misaligned or illegal request (valid with rsp_valid)
DM_enable  out  1  memory access enable
DM_read  out  1  memory read strobe
DM_write  out  1  memory write strobe
DM_address  out  ADDR_W  word address = byte address[ADDR_W+1:2]
DM_in  out  32  write data to memory
DM_out  in  32  memory read data, valid the cycle after a read cycle

Behaviour:
- Moore FSM: IDLE, RD, RDW, WR, RESP. All DM_* outputs decode from registered state/buffers only.
- Reset (rst=0 at edge): state IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0, all DM_* =0, internal buffers 0. Reset overrides any in-flight operation: no further DM strobes, no rsp.
- Accept: handshake when req_valid & req_ready at an edge; addr/funct3/wdata/write are latched. Call the accept cycle "cycle 0".
- Illegal: funct3 in {011,110,111}, or {100,101} with req_write=1.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal or misaligned → RESP; rsp_err=1, rdata=0, no DM strobe. Response in cycle 1.
- SW → WR (cycle 1: DM_enable=1, DM_write=1, DM_read=0, DM_in=wdata) → RESP (cycle 2).
- Load → RD (cycle 1: DM_enable=1, DM_read=1) → RDW (cycle 2: DM_out valid; extracted result registered) → RESP (cycle 3).
- SB/SH → RD (1) → RDW (2: merge into word buffer) → WR (3) → RESP (4).
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE. No response back-pressure.
- Next request accepted no earlier than the cycle after RESP.
- Lanes are little-endian: lane k = bits[8k+7:8k], k=addr[1:0]; half selected by addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Merge: SB replaces lane addr[1:0] with wdata[7:0]; SH replaces the half with wdata[15:0]; other bytes come from DM_out.
- Outside RD/WR: DM_enable=DM_read=DM_write=0; DM_address and DM_in hold last value.
- DM_read and DM_write are never both 1.
- req_* inputs are ignored when req_ready=0.

Optional Feature:
LSU_ALIGN_CHECK_EN
- Defined: misaligned/illegal detection as above.
- Undefined: rsp_err tied 0.
  - Misaligned addresses are aligned down (H: addr[0] cleared; W: addr[1:0] cleared).
  - Illegal funct3 executes as a word access.
  - Timing is that of the resulting legal operation.

Test Plan:
- Reset: rst=0 two cycles mid-stream → all DM_* =0, rsp_valid=0, rsp_err=0; req_ready=1 the first cycle after release.
- SW addr 0x0010, wdata 0xDEADBEEF → cycle 1 DM_enable=1, DM_write=1, DM_address=0x004, DM_in=0xDEADBEEF; cycle 2 rsp_valid=1, rsp_err=0.
- Word 0x004=0xDEADBEEF, each load → cycle 3 rsp_valid with:
  - LB 0x0013 → 0xFFFFFFDE
  - LBU 0x0013 → 0x000000DE
  - LH 0x0012 → 0xFFFFDEAD
  - LHU 0x0010 → 0x0000BEEF
  - LW 0x0010 → 0xDEADBEEF
- SB 0x0011, wdata 0x00000055 on 0xDEADBEEF → cycle 1 DM_read=1; cycle 3 DM_write=1, DM_in=0xDEAD55EF; cycle 4 rsp_valid. Then LW 0x0010 → 0xDEAD55EF.
- LW 0x0012 / funct3=011:
  - macro on → cycle 1 rsp_valid=1, rsp_err=1, rdata=0, DM_enable never 1.
  - macro off → LW reads word 0x004.
- rst=0 during RDW of SH 0x0012 → DM_write never asserted, rsp_valid stays 0; memory word unchanged; next request accepted normally.

Source files
------------

// File: rtl/lsu_dm_master_if.sv
// lsu_dm_master_if: core request/response handshake plus word-addressed
// data-memory port of the load/store unit, grouped into one bundle.
// The master modport is the LSU's view; the slave modport is the
// environment's view (core and data memory).
interface lsu_dm_master_if #(
    parameter int ADDR_W = 12
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              DM_enable;
    logic              DM_read;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_address;
    logic [31:0]       DM_in;
    logic [31:0]       DM_out;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, DM_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output DM_enable, DM_read, DM_write, DM_address, DM_in
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, DM_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  DM_enable, DM_read, DM_write, DM_address, DM_in
    );
endinterface

// File: rtl/lsu_dm_master.sv
// lsu_dm_master: load/store initiator driving a word-addressed data memory
// with a one-cycle registered read. Loads extract and extend bytes/halves;
// sub-word stores are done as read-modify-write of the whole word.
// Optional macro LSU_ALIGN_CHECK_EN: when defined, illegal funct3 and
// misaligned addresses complete immediately with rsp_err=1; when undefined,
// rsp_err is 0, misaligned addresses are aligned down and illegal funct3
// codes execute as word accesses.
module lsu_dm_master #(
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    lsu_dm_master_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_write;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_dm_address;
    logic [31:0]       r_dm_in;

    logic              w_accept;
    logic              w_illegal;
    logic              w_err;
    logic [2:0]        w_funct3;
    logic [ADDR_W+1:0] w_addr;
    logic              w_store_word;

    logic [4:0]        w_byte_shift;
    logic [4:0]        w_lane_shift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_mask;
    logic [31:0]       w_merge;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // Classify the incoming request and produce the size/address actually executed
    always_comb begin
        w_illegal = (bus.req_funct3 == 3'b011) ||
                    (bus.req_funct3[2:1] == 2'b11) ||
                    (bus.req_funct3[2] && bus.req_write);
        w_err     = 1'b0;
        w_funct3  = bus.req_funct3;
        w_addr    = bus.req_addr;
`ifdef LSU_ALIGN_CHECK_EN
        if (w_illegal) begin
            w_err = 1'b1;
        end else if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
            w_err = 1'b1;
        end else if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
`else
        if (w_illegal) begin
            w_funct3 = 3'b010;
        end
        if (w_funct3[1:0] == 2'b01) begin
            w_addr[0] = 1'b0;
        end else if (w_funct3[1:0] == 2'b10) begin
            w_addr[1:0] = 2'b00;
        end
`endif
        w_store_word = bus.req_write && (w_funct3[1:0] == 2'b10);
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        w_byte_shift = {r_lane, 3'b000};
        w_lane_shift = w_byte_shift;
        w_mask       = 32'h0000_00FF;
        w_byte       = 8'(bus.DM_out >> w_byte_shift);
        w_half       = r_lane[1] ? bus.DM_out[31:16] : bus.DM_out[15:0];
        w_load       = bus.DM_out;
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load = bus.DM_out;
        endcase
        if (r_funct3[1:0] == 2'b01) begin
            w_mask       = 32'h0000_FFFF;
            w_lane_shift = {r_lane[1], 4'b0000};
        end
        w_merge = (bus.DM_out & ~(w_mask << w_lane_shift)) |
                  ((r_wdata & w_mask) << w_lane_shift);
    end

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing of the access phases
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = S_RESP;
                    end else if (w_store_word) begin
                        w_next_state = S_WR;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_RD:    w_next_state = S_RDW;
            S_RDW:   w_next_state = r_write ? S_WR : S_RESP;
            S_WR:    w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request capture, load result and write-word buffers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 32'h0;
            r_err        <= 1'b0;
            r_rdata      <= 32'h0;
            r_dm_address <= '0;
            r_dm_in      <= 32'h0;
        end else begin
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_funct3 <= w_funct3;
                r_lane   <= w_addr[1:0];
                r_wdata  <= bus.req_wdata;
                r_err    <= w_err;
                r_rdata  <= 32'h0;
                if (!w_err) begin
                    r_dm_address <= w_addr[ADDR_W+1:2];
                end
                if (!w_err && w_store_word) begin
                    r_dm_in <= bus.req_wdata;
                end
            end
            if (r_state == S_RDW) begin
                if (r_write) begin
                    r_dm_in <= w_merge;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_err    = (r_state == S_RESP) && r_err;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.DM_enable  = (r_state == S_RD) || (r_state == S_WR);
    assign bus.DM_read    = (r_state == S_RD);
    assign bus.DM_write   = (r_state == S_WR);
    assign bus.DM_address = r_dm_address;
    assign bus.DM_in      = r_dm_in;

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb_lsu_dm_master: directed bench for lsu_dm_master with a behavioural
// word memory (one-cycle registered read). Expectations that depend on
// LSU_ALIGN_CHECK_EN follow the same macro.
module tb_lsu_dm_master;

    localparam int ADDR_W = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] dmOut = 32'h0;
    int          checks = 0;
    int          errors = 0;

    lsu_dm_master_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_dm_master #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    assign bus.DM_out = dmOut;

    // Behavioural data memory: registered read, whole-word write
    always @(posedge clk) begin
        if (bus.DM_enable && bus.DM_write) begin
            mem[bus.DM_address] <= bus.DM_in;
        end
        if (bus.DM_enable && bus.DM_read) begin
            dmOut <= mem[bus.DM_address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                                 input logic [ADDR_W+1:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        nextCycle();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'h0;
    endtask

    task automatic runLoad(input string tag, input logic [2:0] f3,
                           input logic [ADDR_W+1:0] addr, input logic [31:0] exp);
        applyStimulus(1'b0, f3, addr, 32'h0);
        checkOutput({tag, " c1 strobes"}, {29'h0, bus.DM_enable, bus.DM_read, bus.DM_write}, 32'h6);
        checkOutput({tag, " c1 addr"}, 32'(bus.DM_address), 32'(addr[ADDR_W+1:2]));
        nextCycle();
        checkOutput({tag, " c2 quiet"}, {30'h0, bus.DM_enable, bus.rsp_valid}, 32'h0);
        nextCycle();
        checkOutput({tag, " c3 valid"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h2);
        checkOutput({tag, " c3 rdata"}, bus.rsp_rdata, exp);
        nextCycle();
        checkOutput({tag, " idle"}, {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
    endtask

    task automatic runSubStore(input string tag, input logic [2:0] f3,
                               input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expWord);
        applyStimulus(1'b1, f3, addr, wdata);
        checkOutput({tag, " c1 strobes"}, {29'h0, bus.DM_enable, bus.DM_read, bus.DM_write}, 32'h6);
        nextCycle();
        checkOutput({tag, " c2 quiet"}, {31'h0, bus.DM_enable}, 32'h0);
        nextCycle();
        checkOutput({tag, " c3 strobes"}, {29'h0, bus.DM_enable, bus.DM_read, bus.DM_write}, 32'h5);
        checkOutput({tag, " c3 DM_in"}, bus.DM_in, expWord);
        checkOutput({tag, " c3 addr"}, 32'(bus.DM_address), 32'(addr[ADDR_W+1:2]));
        nextCycle();
        checkOutput({tag, " c4 valid"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h2);
        checkOutput({tag, " c4 rdata"}, bus.rsp_rdata, 32'h0);
        nextCycle();
    endtask

    task automatic runErr(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [ADDR_W+1:0] addr);
        applyStimulus(wr, f3, addr, 32'h0);
        checkOutput({tag, " c1 valid/err"}, {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h3);
        checkOutput({tag, " c1 rdata"}, bus.rsp_rdata, 32'h0);
        checkOutput({tag, " c1 no DM"}, {31'h0, bus.DM_enable}, 32'h0);
        nextCycle();
        checkOutput({tag, " c2 idle"}, {29'h0, bus.req_ready, bus.rsp_valid, bus.DM_enable}, 32'h4);
    endtask

    // Directed test sequence
    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'h0;

        rst = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("reset strobes", {28'h0, bus.DM_enable, bus.DM_read, bus.DM_write, bus.rsp_valid}, 32'h0);
        checkOutput("reset err", {31'h0, bus.rsp_err}, 32'h0);
        rst = 1'b1;
        nextCycle();
        checkOutput("reset ready", {31'h0, bus.req_ready}, 32'h1);

        // SW 0x0010
        applyStimulus(1'b1, 3'b010, 14'h0010, 32'hDEADBEEF);
        checkOutput("sw c1 strobes", {29'h0, bus.DM_enable, bus.DM_read, bus.DM_write}, 32'h5);
        checkOutput("sw c1 addr", 32'(bus.DM_address), 32'h004);
        checkOutput("sw c1 DM_in", bus.DM_in, 32'hDEADBEEF);
        nextCycle();
        checkOutput("sw c2 valid", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h2);
        checkOutput("sw c2 ready", {31'h0, bus.req_ready}, 32'h0);
        nextCycle();
        checkOutput("sw mem", mem[4], 32'hDEADBEEF);

        runLoad("lb",  3'b000, 14'h0013, 32'hFFFFFFDE);
        runLoad("lbu", 3'b100, 14'h0013, 32'h000000DE);
        runLoad("lh",  3'b001, 14'h0012, 32'hFFFFDEAD);
        runLoad("lhu", 3'b101, 14'h0010, 32'h0000BEEF);
        runLoad("lw",  3'b010, 14'h0010, 32'hDEADBEEF);
        runLoad("lb0", 3'b000, 14'h0010, 32'hFFFFFFEF);

        runSubStore("sb", 3'b000, 14'h0011, 32'h00000055, 32'hDEAD55EF);
        runLoad("lw after sb", 3'b010, 14'h0010, 32'hDEAD55EF);
        runSubStore("sh", 3'b001, 14'h0012, 32'hFFFF1234, 32'h123455EF);
        runLoad("lw after sh", 3'b010, 14'h0010, 32'h123455EF);

`ifdef LSU_ALIGN_CHECK_EN
        runErr("lw mis", 1'b0, 3'b010, 14'h0012);
        runErr("f3 011", 1'b0, 3'b011, 14'h0010);
        runErr("sbu ill", 1'b1, 3'b100, 14'h0010);
`else
        runLoad("lw mis", 3'b010, 14'h0012, 32'h123455EF);
        runLoad("f3 011", 3'b011, 14'h0010, 32'h123455EF);
        runLoad("lh mis", 3'b001, 14'h0013, 32'h00001234);
`endif

        // Reset during the RDW phase of an SH
        applyStimulus(1'b1, 3'b001, 14'h0012, 32'h0000AAAA);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("rst rdw strobes", {28'h0, bus.DM_enable, bus.DM_read, bus.DM_write, bus.rsp_valid}, 32'h0);
        checkOutput("rst rdw addr", 32'(bus.DM_address), 32'h0);
        checkOutput("rst rdw DM_in", bus.DM_in, 32'h0);
        nextCycle();
        checkOutput("rst rdw hold", {30'h0, bus.DM_write, bus.rsp_valid}, 32'h0);
        rst = 1'b1;
        nextCycle();
        checkOutput("rst rdw ready", {30'h0, bus.req_ready, bus.rsp_valid}, 32'h2);
        checkOutput("rst rdw mem", mem[4], 32'h123455EF);
        runLoad("lw after rst", 3'b010, 14'h0010, 32'h123455EF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
